instruction_fetch: RTL and testbench

Fetch stage of the WdPM microprocessor, directly downstream of `program_counter`. It samples the counter's `DATA` output, addresses the synchronous program ROM, latches the returned word into an instruction register, splits it into opcode and operand, and pulses the counter's `CE` so the counter advances once per fetched instruction. A ready/done handshake with the execute stage holds the next fetch until the current instruction has retired.

---
 rtl/instruction_fetch.sv | 129 ++++++++++++
 tb/tb_instruction_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// WdPM fetch stage: addresses the synchronous program ROM from the PC, latches the
// instruction register and pulses the PC increment once per instruction. Optional halt: FETCH_HALT_EN.
module instruction_fetch #(
    parameter int ADDR_W   = 4,
    parameter int INSTR_W  = 8,
    parameter int OPCODE_W = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [ADDR_W-1:0]            PC_ADDR,
    output logic                         PC_CE,
    output logic [ADDR_W-1:0]            MEM_ADDR,
    input  logic [INSTR_W-1:0]           MEM_DATA,
    output logic [INSTR_W-1:0]           INSTR,
    output logic [OPCODE_W-1:0]          OPCODE,
    output logic [INSTR_W-OPCODE_W-1:0]  OPERAND,
    output logic                         INSTR_VALID,
    input  logic                         EXEC_DONE,
    output logic                         HALT
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {S_ADDR, S_READ, S_LATCH, S_EXEC, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_ADDR, S_READ, S_LATCH, S_EXEC} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  pc_ce_q, pc_ce_d;
`ifdef FETCH_HALT_EN
    logic                  halt_q, halt_d;
    logic                  halt_opcode;

    assign halt_opcode = (MEM_DATA[INSTR_W-1 -: OPCODE_W] == {OPCODE_W{1'b1}});
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_ADDR;
            mem_addr_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            pc_ce_q    <= 1'b0;
`ifdef FETCH_HALT_EN
            halt_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            pc_ce_q    <= pc_ce_d;
`ifdef FETCH_HALT_EN
            halt_q     <= halt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        pc_ce_d    = pc_ce_q;
`ifdef FETCH_HALT_EN
        halt_d     = halt_q;
`endif
        case (state_q)
            S_ADDR: begin
                mem_addr_d = PC_ADDR;
                state_d    = S_READ;
            end
            // ROM is sampling MEM_ADDR this cycle; its data arrives for S_LATCH.
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                instr_d = MEM_DATA;
`ifdef FETCH_HALT_EN
                if (halt_opcode) begin
                    // No PC_CE here, so the counter stays parked on the HLT address.
                    halt_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_HALT;
                end else begin
                    valid_d = 1'b1;
                    pc_ce_d = 1'b1;
                    state_d = S_EXEC;
                end
`else
                valid_d = 1'b1;
                pc_ce_d = 1'b1;
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                pc_ce_d = 1'b0;
                if (EXEC_DONE) begin
                    valid_d = 1'b0;
                    state_d = S_ADDR;
                end
            end
`ifdef FETCH_HALT_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_ADDR;
            end
        endcase
    end

    assign PC_CE       = pc_ce_q;
    assign MEM_ADDR    = mem_addr_q;
    assign INSTR       = instr_q;
    assign OPCODE      = instr_q[INSTR_W-1 -: OPCODE_W];
    assign OPERAND     = instr_q[INSTR_W-OPCODE_W-1:0];
    assign INSTR_VALID = valid_q;
`ifdef FETCH_HALT_EN
    assign HALT        = halt_q;
`else
    assign HALT        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous ROM, a behavioural program counter, a
// timeline model of the fetch cycle checked every cycle, plus directed literal checks.
module tb_instruction_fetch;

    logic       CLK;
    logic       RST;
    logic [3:0] PC_ADDR;
    logic       PC_CE;
    logic [3:0] MEM_ADDR;
    logic [7:0] MEM_DATA;
    logic [7:0] INSTR;
    logic [3:0] OPCODE;
    logic [3:0] OPERAND;
    logic       INSTR_VALID;
    logic       EXEC_DONE;
    logic       HALT;

    instruction_fetch #(.ADDR_W(4), .INSTR_W(8), .OPCODE_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC_ADDR    (PC_ADDR),
        .PC_CE      (PC_CE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .INSTR      (INSTR),
        .OPCODE     (OPCODE),
        .OPERAND    (OPERAND),
        .INSTR_VALID(INSTR_VALID),
        .EXEC_DONE  (EXEC_DONE),
        .HALT       (HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Program ROM, one-cycle synchronous read.
    logic [7:0] rom [16];
    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h80 | 8'(i);
        rom[0]  = 8'h12;
        rom[1]  = 8'h34;
        rom[2]  = 8'hF0;
        rom[3]  = 8'h56;
        rom[15] = 8'h77;
    end
    always @(posedge CLK) MEM_DATA <= rom[MEM_ADDR];

    // Program counter: reset, load, increment on CE, natural 4-bit wrap.
    logic       pc_rst, pc_load;
    logic [3:0] pc_load_val;
    logic [3:0] pc;
    always @(posedge CLK) begin
        if (pc_rst)       pc <= 4'h0;
        else if (pc_load) pc <= pc_load_val;
        else if (PC_CE)   pc <= pc + 4'h1;
    end
    assign PC_ADDR = pc;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a fetch starts on an address edge (d=0); the word appears
    // two edges later together with a single-edge PC_CE; the instruction retires
    // on any later edge with EXEC_DONE, and the next address edge follows at once.
    int         cyc = 0;
    int         t_start = -100;
    int         next_fetch = 0;
    int         d;
    logic [3:0] f_addr = 4'h0;
    logic [3:0] e_addr = 4'h0;
    logic [7:0] e_instr = 8'h00;
    bit         e_valid = 1'b0, e_ce = 1'b0, e_halt = 1'b0, halted = 1'b0;
    bit         is_hlt;

    initial forever begin
        @(posedge CLK);
        cyc++;
        if (RST) begin
            e_addr = 4'h0; e_instr = 8'h00; e_valid = 1'b0; e_ce = 1'b0;
            e_halt = 1'b0; halted = 1'b0;
            next_fetch = cyc + 1;
            t_start = -100;
        end else if (!halted) begin
            if (cyc == next_fetch) begin
                t_start = cyc;
                f_addr  = pc;
                e_addr  = pc;
            end
            d = cyc - t_start;
            e_ce = 1'b0;
            if (d == 2) begin
                e_instr = rom[f_addr];
`ifdef FETCH_HALT_EN
                is_hlt = (rom[f_addr][7:4] == 4'hF);
`else
                is_hlt = 1'b0;
`endif
                if (is_hlt) begin
                    e_halt = 1'b1;
                    e_valid = 1'b0;
                    halted = 1'b1;
                end else begin
                    e_valid = 1'b1;
                    e_ce = 1'b1;
                end
            end else if (d >= 3 && EXEC_DONE) begin
                e_valid = 1'b0;
                next_fetch = cyc + 1;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            cmp("model MEM_ADDR", MEM_ADDR, e_addr);
            cmp("model INSTR", INSTR, e_instr);
            cmp("model OPCODE", OPCODE, e_instr[7:4]);
            cmp("model OPERAND", OPERAND, e_instr[3:0]);
            cmp("model INSTR_VALID", INSTR_VALID, e_valid);
            cmp("model PC_CE", PC_CE, e_ce);
            cmp("model HALT", HALT, e_halt);
        end
    end

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; pc_rst = 1'b1; pc_load = 1'b0; pc_load_val = 4'h0; EXEC_DONE = 1'b1;
        tick; tick;
        chk_en = 1'b1;
        cmp("reset INSTR", INSTR, 8'h00);
        cmp("reset MEM_ADDR", MEM_ADDR, 4'h0);
        cmp("reset VALID", INSTR_VALID, 1'b0);
        cmp("reset PC_CE", PC_CE, 1'b0);
        cmp("reset HALT", HALT, 1'b0);

        // Back-to-back fetch with EXEC_DONE tied high.
        RST = 1'b0; pc_rst = 1'b0;
        tick; cmp("E0 MEM_ADDR", MEM_ADDR, 4'h0);
        tick; tick;
        cmp("E2 INSTR", INSTR, 8'h12);
        cmp("E2 OPCODE", OPCODE, 4'h1);
        cmp("E2 OPERAND", OPERAND, 4'h2);
        cmp("E2 VALID", INSTR_VALID, 1'b1);
        cmp("E2 PC_CE", PC_CE, 1'b1);
        tick;
        cmp("E3 PC_CE", PC_CE, 1'b0);
        cmp("E3 PC_ADDR", PC_ADDR, 4'h1);
        tick; tick; tick;
        cmp("E6 INSTR", INSTR, 8'h34);
        cmp("E6 MEM_ADDR", MEM_ADDR, 4'h1);
        $display("txn: back-to-back fetch 12 -> 34 done");

        // Execute stall: instruction held, no extra increment.
        RST = 1'b1; pc_rst = 1'b1; EXEC_DONE = 1'b0;
        tick;
        RST = 1'b0; pc_rst = 1'b0;
        tick; tick; tick;
        cmp("stall first INSTR", INSTR, 8'h12);
        for (int i = 0; i < 5; i++) begin
            tick;
            cmp("stall INSTR", INSTR, 8'h12);
            cmp("stall VALID", INSTR_VALID, 1'b1);
            cmp("stall PC_ADDR", PC_ADDR, 4'h1);
            cmp("stall PC_CE", PC_CE, 1'b0);
        end
        EXEC_DONE = 1'b1;
        tick; cmp("retire VALID", INSTR_VALID, 1'b0);
        tick; cmp("refetch MEM_ADDR", MEM_ADDR, 4'h1);
        $display("txn: 5-cycle stall on 12 done");

        // Reset while the ROM read is in flight.
        RST = 1'b1;
        tick;
        cmp("rst READ MEM_ADDR", MEM_ADDR, 4'h0);
        cmp("rst READ INSTR", INSTR, 8'h00);
        cmp("rst READ PC_CE", PC_CE, 1'b0);
        RST = 1'b0;
        tick; cmp("restart MEM_ADDR", MEM_ADDR, 4'h1);
        tick; tick;
        cmp("restart INSTR", INSTR, 8'h34);

        // Reset on the first execute edge: the pending increment still lands.
        EXEC_DONE = 1'b0; RST = 1'b1;
        tick;
        cmp("rst EXEC INSTR", INSTR, 8'h00);
        cmp("rst EXEC VALID", INSTR_VALID, 1'b0);
        cmp("rst EXEC PC_CE", PC_CE, 1'b0);
        cmp("rst EXEC PC_ADDR", PC_ADDR, 4'h2);
        RST = 1'b0; EXEC_DONE = 1'b1;
        tick; tick; tick;
        cmp("F0 INSTR", INSTR, 8'hF0);
        $display("txn: resets in READ and EXEC done");
`ifdef FETCH_HALT_EN
        cmp("halt HALT", HALT, 1'b1);
        cmp("halt VALID", INSTR_VALID, 1'b0);
        cmp("halt PC_CE", PC_CE, 1'b0);
        for (int i = 0; i < 20; i++) begin
            EXEC_DONE = i[0];
            tick;
            cmp("halt PC_ADDR", PC_ADDR, 4'h2);
            cmp("halt held", HALT, 1'b1);
            cmp("halt VALID held", INSTR_VALID, 1'b0);
        end
        RST = 1'b1; EXEC_DONE = 1'b1;
        tick;
        cmp("halt reset HALT", HALT, 1'b0);
        cmp("halt reset INSTR", INSTR, 8'h00);
        $display("txn: halt on F0 held 20 cycles, cleared by reset");
`else
        cmp("F0 VALID", INSTR_VALID, 1'b1);
        cmp("F0 HALT", HALT, 1'b0);
        cmp("F0 PC_CE", PC_CE, 1'b1);
        cmp("F0 OPCODE", OPCODE, 4'hF);
        tick; tick; tick; tick;
        cmp("after F0 INSTR", INSTR, 8'h56);
        RST = 1'b1;
        tick;
        $display("txn: F0 fetched as ordinary instruction, then 56");
`endif

        // Wrap-around from address 15.
        pc_load = 1'b1; pc_load_val = 4'hF;
        tick;
        pc_load = 1'b0;
        cmp("wrap PC_ADDR", PC_ADDR, 4'hF);
        RST = 1'b0;
        tick; tick; tick;
        cmp("wrap INSTR 77", INSTR, 8'h77);
        cmp("wrap OPCODE", OPCODE, 4'h7);
        tick;
        cmp("wrap PC_ADDR 0", PC_ADDR, 4'h0);
        tick; tick; tick;
        cmp("wrap INSTR 12", INSTR, 8'h12);
        cmp("wrap MEM_ADDR", MEM_ADDR, 4'h0);
        $display("txn: wrap 15 -> 0 done");

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
